// File: rtl/relu_pkg.sv
// Shared types and lane function for the ReLU activation layer.
// relu_f clamps to [0, cap]; plain ReLU is the special case cap = max positive code.
package relu_pkg;

   localparam int DEF_WIDTH   = 10;
   localparam int DEF_NFRAC   = 5;
   localparam int DEF_SIZE    = 32;
   localparam int DEF_CAP_INT = 6;

   typedef logic signed [DEF_WIDTH-1:0] act_t;

   // Sign decided from the MSB alone; zero passes through unchanged.
   function automatic act_t relu_f(act_t x, act_t cap);
      act_t r;
      if (x[DEF_WIDTH-1]) begin
         r = '0;
      end else if (x > cap) begin
         r = cap;
      end else begin
         r = x;
      end
      return r;
   endfunction

endpackage

// File: rtl/relu_lane.sv
// One ReLU lane: combinational relu_f into a sync-reset register, 1-cycle latency.
// RELU_CAP_EN selects clipped ReLU-N with cap CAP_INT << NFRAC; no handshake.
module relu_lane
   import relu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NFRAC   = DEF_NFRAC,
   parameter int CAP_INT = DEF_CAP_INT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] x_i,
   output logic signed [WIDTH-1:0] y_o
);

   localparam int MAX_POS = (1 << (WIDTH - 1)) - 1;
   localparam int CAP_REQ = CAP_INT << NFRAC;
`ifdef RELU_CAP_EN
   localparam bit CAP_ON = 1'b1;
`else
   localparam bit CAP_ON = 1'b0;
`endif
   // Uncapped mode reuses the clamp with the max positive code, which is an identity.
   localparam int CAP_EFF = (CAP_ON && (CAP_REQ < MAX_POS)) ? CAP_REQ : MAX_POS;

   if (WIDTH != DEF_WIDTH) begin : g_width_chk
      $error("relu_lane: WIDTH must match relu_pkg::DEF_WIDTH");
   end
   if (CAP_ON && (CAP_REQ > MAX_POS)) begin : g_cap_chk
      $warning("relu_lane: cap exceeds max positive code, clipping to max");
   end

   act_t y_d;
   act_t y_q;

   assign y_d = relu_f(act_t'(x_i), act_t'(CAP_EFF));

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/relu_activation_layer.sv
// Element-wise ReLU over SIZE independent lanes, one registered stage, always-valid stream.
// Optional clipped mode via RELU_CAP_EN; ports, latency and reset are unaffected by it.
module relu_activation_layer
   import relu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NFRAC   = DEF_NFRAC,
   parameter int SIZE    = DEF_SIZE,
   parameter int CAP_INT = DEF_CAP_INT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] input_data  [SIZE],
   output logic signed [WIDTH-1:0] output_data [SIZE]
);

   for (genvar g = 0; g < SIZE; g++) begin : g_lane
      relu_lane #(
         .WIDTH   (WIDTH),
         .NFRAC   (NFRAC),
         .CAP_INT (CAP_INT)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .x_i (input_data[g]),
         .y_o (output_data[g])
      );
   end

endmodule

// File: tb/tb_relu_activation_layer.sv
// Randomized bench with a per-cycle reference-model compare plus directed literal checks.
module tb_relu_activation_layer;

   localparam int WIDTH = 10;
   localparam int SIZE  = 32;
`ifdef RELU_CAP_EN
   localparam int CAP = 192;
`else
   localparam int CAP = 511;
`endif

   logic                    clk;
   logic                    rst;
   logic signed [WIDTH-1:0] input_data  [SIZE];
   logic signed [WIDTH-1:0] output_data [SIZE];

   int n_cmp = 0;
   int n_bad = 0;

   relu_activation_layer dut (
      .clk         (clk),
      .rst         (rst),
      .input_data  (input_data),
      .output_data (output_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_relu(int v);
      int r;
      r = (v < 0) ? 0 : v;
      if (r > CAP) r = CAP;
      return r;
   endfunction

   // Reference model: expected outputs follow the vector and reset seen at each edge.
   int exp_v [SIZE];
   bit armed = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < SIZE; i++) begin
         exp_v[i] = rst ? 0 : ref_relu(int'(input_data[i]));
      end
      if (rst) armed = 1'b1;
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < SIZE; i++) begin
            n_cmp++;
            if (int'(output_data[i]) != exp_v[i]) begin
               n_bad++;
               $display("FAIL model lane %0d: got %0d expected %0d at %0t",
                        i, int'(output_data[i]), exp_v[i], $time);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_lit(string name, int lane, int expv);
      n_cmp++;
      if (int'(output_data[lane]) != expv) begin
         n_bad++;
         $display("FAIL %s lane %0d: got %0d expected %0d", name, lane,
                  int'(output_data[lane]), expv);
      end
   endtask

   task automatic set_all(int v);
      for (int i = 0; i < SIZE; i++) input_data[i] = WIDTH'(v);
   endtask

   int seq_in  [7] = '{0, 1, 5, -3, -80, 90, 5};
   int seq_out [7] = '{0, 1, 5, 0, 0, 90, 5};
   int ext_in  [3] = '{-512, -1, 511};
   int ext_out [3] = '{0, 0, (511 > CAP) ? CAP : 511};
`ifdef RELU_CAP_EN
   int cap_in  [4] = '{200, 192, 191, -5};
   int cap_out [4] = '{192, 192, 191, 0};
`endif

   initial begin
      rst = 1'b1;
      set_all(90);
      step();
      check_lit("reset_0", 0, 0);
      step();
      for (int i = 0; i < SIZE; i++) check_lit("reset_1", i, 0);
      rst = 1'b0;
      step();
      for (int i = 0; i < SIZE; i++) check_lit("post_reset", i, 90);

      for (int k = 0; k < 7; k++) begin
         input_data[0] = WIDTH'(seq_in[k]);
         step();
         check_lit("seq", 0, seq_out[k]);
      end

      for (int k = 0; k < 3; k++) begin
         set_all(ext_in[k]);
         step();
         for (int i = 0; i < SIZE; i++) check_lit("extreme", i, ext_out[k]);
      end

      for (int i = 0; i < SIZE; i++) input_data[i] = WIDTH'((i % 2 == 1) ? -i : i);
      step();
      for (int i = 0; i < SIZE; i++) check_lit("independent", i, (i % 2 == 1) ? 0 : i);

      set_all(90);
      step();
      check_lit("midrst_pre", 0, 90);
      rst = 1'b1;
      step();
      for (int i = 0; i < SIZE; i++) check_lit("midrst_zero", i, 0);
      rst = 1'b0;
      step();
      for (int i = 0; i < SIZE; i++) check_lit("midrst_post", i, 90);

`ifdef RELU_CAP_EN
      for (int k = 0; k < 4; k++) begin
         set_all(cap_in[k]);
         step();
         for (int i = 0; i < SIZE; i++) check_lit("cap", i, cap_out[k]);
      end
`endif

      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < SIZE; i++) begin
            input_data[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         end
         step();
      end
      rst = 1'b0;
      step();
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
